button_debounce: RTL

Multi-channel push-button conditioner for the hx8k 6502 board, sitting directly upstream of the SoC GPIO-B input port. Each raw, asynchronous, bouncing button pin is synchronised, debounced with a per-channel stability counter, and presented as a clean level plus optional one-cycle rise/fall pulses. The clean levels drive `gpio_b_i[1:0]`; the pulses are available for future IRQ/latch logic.

---
 rtl/button_pkg.sv | 13 +
 rtl/button_debounce_channel.sv | 84 ++++++++
 rtl/button_debounce.sv | 32 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioner.
package button_pkg;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 12000;

  // BUT1/BUT2 are active-low with pull-ups, so the idle level is high.
  localparam logic BTN_IDLE_LEVEL = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// Single-bit synchroniser, stability counter and level/edge registers.
// Edge pulses are built only when BUTTON_DEBOUNCE_EDGE_EN is defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic        RESET_BIT     = BTN_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned      CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle of agreement clears the count, so stability is re-accumulated.
  always_comb begin
    s1_d  = btn_i;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= RESET_BIT;
      s2_q  <= RESET_BIT;
      lvl_q <= RESET_BIT;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_o = lvl_q;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  logic flip;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    flip   = (s2_q != lvl_q) && (cnt_q == CNT_LAST);
    rise_d = flip & s2_q;
    fall_d = flip & ~s2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer feeding GPIO-B; one debounce_channel per pin.
// Optional rise/fall pulses are enabled with BUTTON_DEBOUNCE_EDGE_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned   N             = 2,
  parameter int unsigned   STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic [N-1:0]  RESET_VAL     = {N{BTN_IDLE_LEVEL}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] btn_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VAL[g])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_i[g]),
      .btn_o   (btn_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g])
    );
  end

endmodule
